serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised digit-serial adder/subtractor for the garbled-circuit arithmetic library. It processes an N-bit operand pair as CC slices of W = N/CC bits, least-significant slice first, with one slice per clock and the carry held in a register between slices. Over the 2-bit-per-cycle serial adder it adds a selectable subtract mode, an explicit start/busy/last/done handshake, operation framing by an internal slice counter, and final unsigned carry and signed overflow flags. It sits between operand streaming logic and downstream serial consumers.

## Interface
- N, default 256: total operand width in bits.
- CC, default 128: slices per operation. N % CC must be 0, so W = N/CC. CC = 1 is legal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- start  in  1  begin an operation; slice 0 is presented in the same cycle.
- sub  in  1  0 = a+b, 1 = a-b; sampled only in the start cycle.
- a  in  W  current slice of operand A.
- b  in  W  current slice of operand B.
- c  out  W  current result slice (combinational).
- busy  out  1  a slice is being consumed this cycle.
- last  out  1  current slice is slice CC-1.
- done  out  1  one-cycle pulse in the cycle after the last slice.
- cout  out  1  final carry out of the MSB. In sub mode, 1 means no borrow (A >= B unsigned).
- ovf  out  1  signed two's-complement overflow of the full N-bit result.

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: slices 1..CC-1 still pending.
- Internal registers: state, cnt (slice index, clog2(CC) bits, minimum 1), carry, mode.
- The active slice index is 0 in the start cycle and cnt in RUN.
- Effective mode: mode_eff = sub in the start cycle, the latched mode in RUN.
- Effective B: b_eff = b XOR {W{mode_eff}}.
- Carry in: cin = mode_eff in the start cycle (two's-complement +1), the carry register otherwise.
- Slice sum: {co, c} = a + b_eff + cin. cm is the carry into bit W-1.
- c is driven 0 whenever busy = 0.
- busy = start in IDLE, 1 in RUN.
- last = busy and (active slice index == CC-1).
- Each edge with busy = 1: carry <= co.
- Start edge: mode <= sub, cnt <= 1. The state goes to RUN, or stays IDLE if CC = 1.
- RUN edge: cnt <= cnt+1. On the last slice the state goes to IDLE and cnt <= 0.
- Each edge with last = 1: cout <= co, ovf <= co XOR cm, done <= 1. done <= 0 on all other edges.
- cout and ovf hold until overwritten by the next last slice.
- start while in RUN is ignored; its slice data is treated as the pending slice.
- Back-to-back: start in the cycle after last (state IDLE) is legal. The carry register is never used for slice 0, so no carry leaks between operations.

## Timing
- Reset values: state = IDLE, cnt = 0, carry = 0, mode = 0, done = 0, cout = 0, ovf = 0. Hence busy = 0, last = 0, c = 0.
- rst asserted mid-operation aborts it immediately (asynchronous): busy drops in the same cycle and no done pulse follows.
- Latency: c for slice k is valid combinationally in cycle k, where cycle 0 is the start cycle.
- An operation occupies exactly CC cycles; done, cout and ovf are valid in cycle CC.
- Throughput: one N-bit operation every CC cycles with zero idle cycles between operations.
- CC = 1: start, busy and last coincide in one cycle; done follows in the next cycle.

## Test plan
Unless stated, N = 8, CC = 4, W = 2; slices listed LSB first.
- Add 0xFF + 0x01 (a 3,3,3,3; b 1,0,0,0) -> c 0,0,0,0; last in cycle 3; done = 1 in cycle 4; cout = 1, ovf = 0.
- Sub 0x05 − 0x07 (a 1,1,0,0; b 3,1,0,0; sub = 1) -> c 2,3,3,3 (0xFE); cout = 0 (borrow), ovf = 0.
- Add 0x7F + 0x01 -> c 0,0,0,2 (0x80); cout = 0, ovf = 1. Sub 0x80 − 0x01 -> 0x7F with ovf = 1, cout = 1.
- Back-to-back: op 1 is 0xFF+0x01, then start in cycle 4 with 0x00+0x00 -> second result c 0,0,0,0, no carry leakage; done pulses in cycles 4 and 8; the final flags are cout = 0, ovf = 0.
- rst pulse during cycle 2 of an add -> busy = 0 immediately, no done pulse, cout/ovf = 0. A following start runs a normal full 4-cycle operation. A start asserted in cycle 1 of an operation does not restart it, and done still occurs in cycle 4.
- N = 4, CC = 1: start with a = 0xF, b = 0x1 -> c = 0x0 and last = 1 in the same cycle; done = 1 in the next cycle; cout = 1, ovf = 0.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor. An N-bit operand pair is
// streamed as CC slices of W bits, LSB slice first, one slice per clock, with
// the inter-slice carry held in a register. Produces final unsigned carry and
// signed overflow flags plus a start/busy/last/done handshake.
module serial_addsub #(
  parameter int N  = 256,
  parameter int CC = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [N/CC-1:0]  a,
  input  logic [N/CC-1:0]  b,
  output logic [N/CC-1:0]  c,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             cout,
  output logic             ovf
);

  localparam int W     = N / CC;
  localparam int CNT_W = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CC - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] idx;
  logic             mode_eff;
  logic             cin;
  logic [W-1:0]     b_eff;
  logic [W:0]       sum;
  logic             co;
  logic             cm;

  // State register: all flops, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output / datapath decode: handshake flags and the slice adder.
  always_comb begin
    busy     = (state_q == RUN) || start;
    idx      = (state_q == RUN) ? cnt_q : '0;
    last     = busy && (idx == LAST_IDX);
    // Slice 0 takes mode and the two's-complement +1 straight from the inputs;
    // the carry register is only consulted in RUN, so nothing leaks between ops.
    mode_eff = (state_q == RUN) ? mode_q : sub;
    cin      = (state_q == RUN) ? carry_q : sub;
    b_eff    = b ^ {W{mode_eff}};
    sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    co       = sum[W];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    cm       = sum[W-1] ^ a[W-1] ^ b_eff[W-1];
    c        = busy ? sum[W-1:0] : '0;
    done     = done_q;
    cout     = cout_q;
    ovf      = ovf_q;
  end

  // Next-state: slice framing, carry chaining and final flag capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = busy ? co : carry_q;
    done_d  = last;
    cout_d  = last ? co : cout_q;
    ovf_d   = last ? (co ^ cm) : ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = sub;
          cnt_d   = CNT_W'(1);
          state_d = (CC == 1) ? IDLE : RUN;
        end
      end
      RUN: begin
        // A start seen here is ignored; its data is simply the pending slice.
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: N=8/CC=4 main instance plus an
// N=4/CC=1 instance. Table vectors, hand sequences and random ops checked
// against a plain-arithmetic model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  // main instance, N=8 CC=4
  logic       start, sub;
  logic [1:0] a, b, c;
  logic       busy, last, done, cout, ovf;
  // single-slice instance, N=4 CC=1
  logic       start1, sub1;
  logic [3:0] a1, b1, c1;
  logic       busy1, last1, done1, cout1, ovf1;

  int checks = 0;
  int errors = 0;

  // expected final flags of the op just streamed, and the held values
  logic pend = 1'b0;
  logic pcout, povf;
  logic hcout = 1'b0, hovf = 1'b0;

  always #5 clk = ~clk;

  serial_addsub #(.N(8), .CC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .c(c), .busy(busy), .last(last), .done(done), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.N(4), .CC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .c(c1), .busy(busy1), .last(last1), .done(done1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] c;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full-width unsigned and signed arithmetic.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [7:0] r, output logic co, output logic ov);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    if (s) begin
      ur = ux - uy; sr = sx - sy; co = (ux >= uy);
    end else begin
      ur = ux + uy; sr = sx + sy; co = (ur > 255);
    end
    r  = ur[7:0];
    ov = (sr > 127) || (sr < -128);
  endtask

  // done pulses exactly in the cycle after a last slice; flags then hold.
  task automatic check_done();
    logic was;
    was = pend;
    if (pend) begin
      hcout = pcout; hovf = povf; pend = 1'b0;
    end
    chk("done", done, was);
    chk("cout", cout, hcout);
    chk("ovf", ovf, hovf);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    a = 2'($urandom); b = 2'($urandom); sub = 1'($urandom);
    #1;
    check_done();
    chk("idle_busy", busy, 0);
    chk("idle_last", last, 0);
    chk("idle_c", c, 0);
  endtask

  // Stream one op over 4 cycles. sub is inverted outside the start cycle to
  // confirm it is only sampled at start; dbl re-asserts start in cycle 1.
  task automatic op(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                    input logic [7:0] ec, input logic ecout, input logic eovf,
                    input logic dbl);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = (k == 0) || (k == 1 && dbl);
      sub   = (k == 0) ? osub : ~osub;
      a     = oa[2*k +: 2];
      b     = ob[2*k +: 2];
      #1;
      check_done();
      chk("busy", busy, 1);
      chk("last", last, (k == 3));
      chk("c_slice", c, ec[2*k +: 2]);
    end
    pend = 1'b1; pcout = ecout; povf = eovf;
  endtask

  vec_t tbl[10];

  initial begin
    logic [7:0] ra, rb, rc;
    logic       rs, rco, rov;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[8] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_last", last, 0); chk("rst_c", c, 0);
    chk("rst_done", done, 0); chk("rst_cout", cout, 0); chk("rst_ovf", ovf, 0);
    chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle();

    // table vectors, one idle cycle between ops
    for (int i = 0; i < 10; i++) begin
      op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].c, tbl[i].cout, tbl[i].ovf, 1'b0);
      idle();
    end

    // back-to-back: done in cycles 4 and 8, no carry leak into op 2
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    idle();

    // reset in cycle 2 of an add: busy drops at once, no done, flags cleared
    op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0); // leave flags non-zero
    idle();
    @(negedge clk); start = 1'b1; sub = 1'b0; a = 2'd3; b = 2'd1; #1;
    chk("ab_busy0", busy, 1);
    @(negedge clk); start = 1'b0; a = 2'd3; b = 2'd0; #1;
    chk("ab_busy1", busy, 1);
    @(negedge clk); a = 2'd3; b = 2'd0; rst = 1'b1; #1;
    chk("ab_busy2", busy, 0); chk("ab_c2", c, 0); chk("ab_last2", last, 0);
    chk("ab_cout", cout, 0); chk("ab_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    pend = 1'b0; hcout = 1'b0; hovf = 1'b0;
    idle(); idle();
    // a normal op after the abort, with a spurious start in cycle 1
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle();
    op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    idle();

    // random ops against the model, random 0/1 idle gap
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i % 7 == 0) rb = ra;
      model(ra, rb, rs, rc, rco, rov);
      op(ra, rb, rs, rc, rco, rov, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // CC = 1 instance: start, busy, last in one cycle; done next
    for (int i = 0; i < 3; i++) begin
      logic [3:0] xa, xb, xc; logic xs, xco, xov;
      case (i)
        0: begin xa = 4'hF; xb = 4'h1; xs = 1'b0; xc = 4'h0; xco = 1'b1; xov = 1'b0; end
        1: begin xa = 4'h3; xb = 4'h5; xs = 1'b1; xc = 4'hE; xco = 1'b0; xov = 1'b0; end
        default: begin xa = 4'h7; xb = 4'h1; xs = 1'b0; xc = 4'h8; xco = 1'b0; xov = 1'b1; end
      endcase
      @(negedge clk); start1 = 1'b1; sub1 = xs; a1 = xa; b1 = xb; #1;
      chk("cc1_c", c1, xc); chk("cc1_busy", busy1, 1); chk("cc1_last", last1, 1);
      chk("cc1_done_pre", done1, 0);
      @(negedge clk); start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; #1;
      chk("cc1_done", done1, 1); chk("cc1_cout", cout1, xco); chk("cc1_ovf", ovf1, xov);
      chk("cc1_idle_c", c1, 0); chk("cc1_idle_busy", busy1, 0);
    end
    @(negedge clk); #1;
    chk("cc1_done_drop", done1, 0); chk("cc1_ovf_hold", ovf1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
